// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode types: instruction classes, opcode constants and the
// queued entry format carried by the decode stage.
package legv8_pkg;

  typedef enum logic [2:0] {
    R       = 3'd0,
    I       = 3'd1,
    D       = 3'd2,
    B       = 3'd3,
    CB      = 3'd4,
    ILLEGAL = 3'd5
  } iclass_e;

  // R-type and D-type opcodes occupy instr[31:21]
  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_EOR   = 11'b11001010000;
  localparam logic [10:0] OP_LSL   = 11'b11010011011;
  localparam logic [10:0] OP_LSR   = 11'b11010011010;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;

  // I-type on instr[31:22], B on instr[31:26], CB on instr[31:24]
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } decode_entry_t;

  function automatic logic is_rtype(input logic [10:0] op);
    return (op == OP_ADD)  || (op == OP_ADDS) || (op == OP_SUB) ||
           (op == OP_SUBS) || (op == OP_AND)  || (op == OP_ORR) ||
           (op == OP_EOR)  || (op == OP_LSL)  || (op == OP_LSR);
  endfunction

  function automatic logic is_dtype(input logic [10:0] op);
    return (op == OP_LDUR) || (op == OP_STUR);
  endfunction

endpackage

// File: rtl/legv8_decode_stage_if.sv
// Fetch-side handshake plus decoded head entry toward the execution datapath.
interface legv8_decode_stage_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        flush;

  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  Rn;
  logic [4:0]  Rm;
  logic [4:0]  Rd;
  logic [5:0]  Shamt;
  logic [11:0] Imm12;
  logic [8:0]  Imm9;
  logic [25:0] Imm26;
  logic [18:0] Imm19;
  logic [2:0]  iclass;
  logic        reg2loc;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, Rn, Rm, Rd, Shamt,
           Imm12, Imm9, Imm26, Imm19, iclass, reg2loc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, Rn, Rm, Rd, Shamt,
           Imm12, Imm9, Imm26, Imm19, iclass, reg2loc
  );

endinterface

// File: rtl/legv8_field_decoder.sv
// Slices a LEGv8 word into datapath fields and classifies its opcode.
// Latency: combinational.
// Backpressure: none; pure function of instr.
module legv8_field_decoder
  import legv8_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rn,
  output logic [4:0]  rm,
  output logic [4:0]  rd,
  output logic [5:0]  shamt,
  output logic [11:0] imm12,
  output logic [8:0]  imm9,
  output logic [25:0] imm26,
  output logic [18:0] imm19,
  output iclass_e     iclass,
  output logic        reg2loc
);

  assign rn    = instr[9:5];
  assign rm    = instr[20:16];
  assign rd    = instr[4:0];
  assign shamt = instr[15:10];
  assign imm12 = instr[21:10];
  assign imm9  = instr[20:12];
  assign imm26 = instr[25:0];
  assign imm19 = instr[23:5];

  // Longest opcodes first; the encodings do not overlap across widths.
  always_comb begin
    iclass = ILLEGAL;
    if (is_rtype(instr[31:21])) begin
      iclass = R;
    end else if (is_dtype(instr[31:21])) begin
      iclass = D;
    end else if ((instr[31:22] == OP_ADDI) || (instr[31:22] == OP_SUBI)) begin
      iclass = I;
    end else if ((instr[31:24] == OP_CBZ) || (instr[31:24] == OP_BCOND)) begin
      iclass = CB;
    end else if (instr[31:26] == OP_B) begin
      iclass = B;
    end
  end

  // STUR stores Rt and CBZ tests Rt, both held in the Rd slot.
  assign reg2loc = (instr[31:21] == OP_STUR) || (instr[31:24] == OP_CBZ);

endmodule

// File: rtl/legv8_decode_stage.sv
// LEGv8 decode stage: 2-entry skid queue feeding a combinational field decoder.
// Latency: instruction accepted at edge N appears on the outputs after edge N.
// Backpressure: in_ready drops once both entries are held; flush empties the queue.
module legv8_decode_stage
  import legv8_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  legv8_decode_stage_if.slave  bus
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]    state;
  decode_entry_t head;
  decode_entry_t skid;
  decode_entry_t in_entry;
  logic          head_valid;
  logic          accept;
  logic          pop;

  assign head_valid   = (state != EMPTY);
  assign bus.in_ready = (state != TWO);
  assign accept       = bus.in_valid & bus.in_ready;
  assign pop          = head_valid & bus.out_ready;
  assign in_entry     = '{pc: bus.in_pc, instr: bus.in_instr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else if (bus.flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head  <= in_entry;
            state <= ONE;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            skid  <= in_entry;
            state <= TWO;
          end else if (pop && !accept) begin
            state <= EMPTY;
          end else if (accept && pop) begin
            head <= in_entry;
          end
        end
        TWO: begin
          // in_ready is low here, so only a pop can move the queue
          if (pop) begin
            head  <= skid;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  logic [4:0]  dec_rn;
  logic [4:0]  dec_rm;
  logic [4:0]  dec_rd;
  logic [5:0]  dec_shamt;
  logic [11:0] dec_imm12;
  logic [8:0]  dec_imm9;
  logic [25:0] dec_imm26;
  logic [18:0] dec_imm19;
  iclass_e     dec_iclass;
  logic        dec_reg2loc;

  legv8_field_decoder u_field_decoder (
    .instr   (head.instr),
    .rn      (dec_rn),
    .rm      (dec_rm),
    .rd      (dec_rd),
    .shamt   (dec_shamt),
    .imm12   (dec_imm12),
    .imm9    (dec_imm9),
    .imm26   (dec_imm26),
    .imm19   (dec_imm19),
    .iclass  (dec_iclass),
    .reg2loc (dec_reg2loc)
  );

  // Data outputs read as zero whenever no head entry is held.
  assign bus.out_valid = head_valid;
  assign bus.out_pc    = head_valid ? head.pc    : '0;
  assign bus.out_instr = head_valid ? head.instr : '0;
  assign bus.Rn        = head_valid ? dec_rn     : '0;
  assign bus.Rm        = head_valid ? dec_rm     : '0;
  assign bus.Rd        = head_valid ? dec_rd     : '0;
  assign bus.Shamt     = head_valid ? dec_shamt  : '0;
  assign bus.Imm12     = head_valid ? dec_imm12  : '0;
  assign bus.Imm9      = head_valid ? dec_imm9   : '0;
  assign bus.Imm26     = head_valid ? dec_imm26  : '0;
  assign bus.Imm19     = head_valid ? dec_imm19  : '0;
  assign bus.iclass    = head_valid ? dec_iclass : 3'd0;
  assign bus.reg2loc   = head_valid & dec_reg2loc;

endmodule

// File: tb/tb_legv8_decode_stage.sv
// Directed bench for legv8_decode_stage: queue-based reference model checked every
// cycle, plus hand-computed literal expectations from the LEGv8 encodings.
module tb_legv8_decode_stage;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  legv8_decode_stage_if dif ();

  legv8_decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  legv8_pkg::decode_entry_t q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Classification straight from the ISA opcode table.
  function automatic logic [2:0] exp_class(input logic [31:0] w);
    logic [10:0] o11;
    logic [9:0]  o10;
    logic [7:0]  o8;
    logic [5:0]  o6;
    o11 = w[31:21];
    o10 = w[31:22];
    o8  = w[31:24];
    o6  = w[31:26];
    if (o11 inside {11'b10001011000, 11'b10101011000, 11'b11001011000,
                    11'b11101011000, 11'b10001010000, 11'b10101010000,
                    11'b11001010000, 11'b11010011011, 11'b11010011010})
      return legv8_pkg::R;
    if (o11 inside {11'b11111000010, 11'b11111000000}) return legv8_pkg::D;
    if (o10 inside {10'b1001000100, 10'b1101000100})   return legv8_pkg::I;
    if (o8 inside {8'b10110100, 8'b01010100})          return legv8_pkg::CB;
    if (o6 == 6'b000101)                               return legv8_pkg::B;
    return legv8_pkg::ILLEGAL;
  endfunction

  // Expected {Rn,Rm,Rd,Shamt,Imm12,Imm9,Imm26,Imm19,iclass,reg2loc}
  function automatic logic [90:0] exp_fields(input logic [31:0] w);
    logic [31:0] v;
    logic        r2l;
    v   = w;
    r2l = (w[31:21] == 11'b11111000000) || (w[31:24] == 8'b10110100);
    return {5'((v >> 5) % 32), 5'((v >> 16) % 32), 5'(v % 32),
            6'((v >> 10) % 64), 12'((v >> 10) % 4096), 9'((v >> 12) % 512),
            26'(v % (1 << 26)), 19'((v >> 5) % (1 << 19)),
            exp_class(w), r2l};
  endfunction

  task automatic model_edge();
    bit acc;
    bit pp;
    legv8_pkg::decode_entry_t e;
    if (reset) begin
      q.delete();
    end else begin
      acc = dif.in_valid && (q.size() < 2);
      pp  = (q.size() > 0) && dif.out_ready;
      e.pc    = dif.in_pc;
      e.instr = dif.in_instr;
      if (dif.flush) begin
        q.delete();
      end else begin
        if (pp)  void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
  endtask

  task automatic compare_all();
    logic [90:0] ef;
    logic [90:0] af;
    logic        ev;
    logic        er;
    logic [63:0] epc;
    logic [31:0] ein;
    if (q.size() == 0) begin
      ev = 1'b0; er = 1'b1; epc = '0; ein = '0; ef = '0;
    end else begin
      ev = 1'b1; er = (q.size() < 2); epc = q[0].pc; ein = q[0].instr;
      ef = exp_fields(q[0].instr);
    end
    af = {dif.Rn, dif.Rm, dif.Rd, dif.Shamt, dif.Imm12, dif.Imm9, dif.Imm26,
          dif.Imm19, dif.iclass, dif.reg2loc};
    chk("model out_valid", 128'(dif.out_valid), 128'(ev));
    chk("model in_ready",  128'(dif.in_ready),  128'(er));
    chk("model out_pc",    128'(dif.out_pc),    128'(epc));
    chk("model out_instr", 128'(dif.out_instr), 128'(ein));
    chk("model fields",    128'(af),            128'(ef));
  endtask

  // Drive one cycle's inputs, advance the model on the edge, compare mid-cycle.
  task automatic cyc(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                     input bit fl, input bit ordy);
    dif.in_valid  = v;
    dif.in_instr  = ins;
    dif.in_pc     = pc;
    dif.flush     = fl;
    dif.out_ready = ordy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  localparam logic [31:0] ADDS_X3 = 32'hAB020023;
  localparam logic [31:0] LDUR_X4 = 32'hF84080A4;
  localparam logic [31:0] STUR_X4 = 32'hF80080A4;
  localparam logic [31:0] ADDI_X1 = 32'h91000401;
  localparam logic [31:0] SUBI_X2 = 32'hD1000422;
  localparam logic [31:0] EOR_X3  = 32'hCA020023;
  localparam logic [31:0] B_M1    = 32'h17FFFFFF;
  localparam logic [31:0] CBZ_X7  = 32'hB4000047;
  localparam logic [31:0] BCOND   = 32'h54000040;
  localparam logic [31:0] LSL_X9  = 32'hD3601029;
  localparam logic [31:0] ORR_X5  = 32'hAA0400C5;

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    dif.in_valid = 1'b0; dif.in_instr = '0; dif.in_pc = '0;
    dif.flush = 1'b0; dif.out_ready = 1'b0;

    cyc(0, 32'h0, 64'h0, 0, 0);
    cyc(0, 32'h0, 64'h0, 0, 0);
    chk("reset out_valid", 128'(dif.out_valid), 128'd0);
    chk("reset in_ready",  128'(dif.in_ready),  128'd1);
    chk("reset out_instr", 128'(dif.out_instr), 128'd0);
    reset = 1'b0;
    cyc(0, 32'h0, 64'h0, 0, 1);
    chk("idle out_valid", 128'(dif.out_valid), 128'd0);
    chk("idle out_pc",    128'(dif.out_pc),    128'd0);

    cyc(1, ADDS_X3, 64'h100, 0, 1);
    chk("adds out_valid", 128'(dif.out_valid), 128'd1);
    chk("adds Rn",      128'(dif.Rn),      128'd1);
    chk("adds Rm",      128'(dif.Rm),      128'd2);
    chk("adds Rd",      128'(dif.Rd),      128'd3);
    chk("adds iclass",  128'(dif.iclass),  128'(legv8_pkg::R));
    chk("adds reg2loc", 128'(dif.reg2loc), 128'd0);

    cyc(1, LDUR_X4, 64'h104, 0, 1);
    chk("ldur Imm9",    128'(dif.Imm9),    128'd8);
    chk("ldur Rn",      128'(dif.Rn),      128'd5);
    chk("ldur Rd",      128'(dif.Rd),      128'd4);
    chk("ldur iclass",  128'(dif.iclass),  128'(legv8_pkg::D));
    chk("ldur reg2loc", 128'(dif.reg2loc), 128'd0);
    cyc(1, STUR_X4, 64'h108, 0, 1);
    chk("stur out_valid", 128'(dif.out_valid), 128'd1);
    chk("stur Imm9",      128'(dif.Imm9),      128'd8);
    chk("stur reg2loc",   128'(dif.reg2loc),   128'd1);
    chk("stur out_pc",    128'(dif.out_pc),    128'h108);
    cyc(0, 32'h0, 64'h0, 0, 1);
    chk("drain out_valid", 128'(dif.out_valid), 128'd0);

    // Back-pressure: three offers against a stalled consumer
    cyc(1, ADDI_X1, 64'h0, 0, 0);
    chk("bp1 in_ready", 128'(dif.in_ready), 128'd1);
    chk("bp1 iclass",   128'(dif.iclass),   128'(legv8_pkg::I));
    cyc(1, SUBI_X2, 64'h4, 0, 0);
    chk("bp2 in_ready", 128'(dif.in_ready), 128'd0);
    cyc(1, EOR_X3, 64'h8, 0, 0);
    chk("bp3 in_ready", 128'(dif.in_ready), 128'd0);
    chk("bp3 head pc",  128'(dif.out_pc),   128'h0);
    cyc(1, EOR_X3, 64'h8, 0, 1);
    chk("drain1 pc", 128'(dif.out_pc), 128'h4);
    cyc(1, EOR_X3, 64'h8, 0, 1);
    chk("drain2 pc", 128'(dif.out_pc), 128'h8);
    chk("drain2 Rd", 128'(dif.Rd),     128'd3);
    cyc(0, 32'h0, 64'h0, 0, 1);
    chk("drain3 out_valid", 128'(dif.out_valid), 128'd0);

    // Flush while full, with a same-cycle offer that must be dropped
    cyc(1, ADDS_X3, 64'h200, 0, 0);
    cyc(1, LDUR_X4, 64'h204, 0, 0);
    cyc(1, STUR_X4, 64'h208, 1, 0);
    chk("flush out_valid", 128'(dif.out_valid), 128'd0);
    chk("flush in_ready",  128'(dif.in_ready),  128'd1);
    cyc(0, 32'h0, 64'h0, 0, 1);
    chk("flush dropped", 128'(dif.out_valid), 128'd0);

    // Branch classes, immediates and an illegal word
    cyc(1, B_M1, 64'h300, 0, 1);
    chk("b Imm26",  128'(dif.Imm26),  128'h3FFFFFF);
    chk("b iclass", 128'(dif.iclass), 128'(legv8_pkg::B));
    cyc(1, CBZ_X7, 64'h304, 0, 1);
    chk("cbz Imm19",   128'(dif.Imm19),   128'd2);
    chk("cbz Rd",      128'(dif.Rd),      128'd7);
    chk("cbz iclass",  128'(dif.iclass),  128'(legv8_pkg::CB));
    chk("cbz reg2loc", 128'(dif.reg2loc), 128'd1);
    cyc(1, 32'h0, 64'h308, 0, 1);
    chk("zero iclass", 128'(dif.iclass),    128'(legv8_pkg::ILLEGAL));
    chk("zero valid",  128'(dif.out_valid), 128'd1);
    cyc(1, BCOND, 64'h30C, 0, 1);
    chk("bcond reg2loc", 128'(dif.reg2loc), 128'd0);
    cyc(1, LSL_X9, 64'h310, 0, 1);
    chk("lsl Shamt", 128'(dif.Shamt), 128'd4);
    cyc(1, ORR_X5, 64'h314, 0, 0);
    cyc(1, ADDI_X1, 64'h318, 0, 0);

    // Asynchronous reset while full clears the stage before the next edge
    #1 reset = 1'b1;
    #1;
    chk("async out_valid", 128'(dif.out_valid), 128'd0);
    chk("async in_ready",  128'(dif.in_ready),  128'd1);
    chk("async out_pc",    128'(dif.out_pc),    128'd0);
    q.delete();
    cyc(0, 32'h0, 64'h0, 0, 1);
    reset = 1'b0;
    cyc(0, 32'h0, 64'h0, 0, 1);
    chk("post-reset empty", 128'(dif.out_valid), 128'd0);
    cyc(1, SUBI_X2, 64'h400, 0, 1);
    chk("post-reset pc", 128'(dif.out_pc), 128'h400);
    cyc(0, 32'h0, 64'h0, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
